// File: rtl/arp_responder.sv
// ARP responder: watches the Rx byte stream for ARP requests aimed at our IP
// and answers each with a 60-byte reply (no preamble/CRC) on a valid/ready byte port.
module arp_responder #(
   parameter logic [7:0] myIP_1 = 8'd192,
   parameter logic [7:0] myIP_2 = 8'd168,
   parameter logic [7:0] myIP_3 = 8'd3,
   parameter logic [7:0] myIP_4 = 8'd40,
   parameter logic [7:0] myPA_1 = 8'h16,
   parameter logic [7:0] myPA_2 = 8'hFD,
   parameter logic [7:0] myPA_3 = 8'h22,
   parameter logic [7:0] myPA_4 = 8'h04,
   parameter logic [7:0] myPA_5 = 8'hB1,
   parameter logic [7:0] myPA_6 = 8'h61
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        RxFrame,
   input  logic [7:0]  RxByte,
   input  logic        RxByteValid,
   input  logic        RxFrameEnd,
   input  logic        RxCRC_OK,
   output logic [7:0]  TxByte,
   output logic        TxValid,
   output logic        TxLast,
   input  logic        TxReady,
   output logic        Busy,
   output logic [15:0] ReplyCount,
   output logic [15:0] DropCount
);

   // state | meaning
   // IDLE  | no reply pending; a matching request starts a reply
   // SEND  | streaming reply bytes 0..59; further requests are dropped
   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [47:0] MY_PA = {myPA_1, myPA_2, myPA_3, myPA_4, myPA_5, myPA_6};
   localparam logic [31:0] MY_IP = {myIP_1, myIP_2, myIP_3, myIP_4};

   function automatic logic [7:0] pick6(input logic [47:0] v, input int k);
      return 8'(v >> (8 * (5 - k)));
   endfunction

   function automatic logic [7:0] pick4(input logic [31:0] v, input int k);
      return 8'(v >> (8 * (3 - k)));
   endfunction

   logic [6:0]  rx_index, idx_nxt;
   logic        bcast_ok, bcast_nxt;
   logic        ucast_ok, ucast_nxt;
   logic        hdr_ok, hdr_nxt;
   logic [47:0] sha, sha_nxt;
   logic [31:0] spa, spa_nxt;
   logic        byte_in;
   logic        chk_en;
   logic [7:0]  chk_val;
   logic        accept;

   state_t      state, state_nxt;
   logic [5:0]  tx_index, tx_index_nxt;
   logic [47:0] reply_sha;
   logic [31:0] reply_spa;
   logic [7:0]  tx_byte;
   logic        load, drop, done;

   assign byte_in = RxFrame & RxByteValid;

   always_comb begin
      chk_en  = 1'b1;
      chk_val = 8'h00;
      case (rx_index) inside
         7'd12:         chk_val = 8'h08;
         7'd13:         chk_val = 8'h06;
         7'd14:         chk_val = 8'h00;
         7'd15:         chk_val = 8'h01;
         7'd16:         chk_val = 8'h08;
         7'd17:         chk_val = 8'h00;
         7'd18:         chk_val = 8'h06;
         7'd19:         chk_val = 8'h04;
         7'd20:         chk_val = 8'h00;
         7'd21:         chk_val = 8'h01;
         [7'd38:7'd41]: chk_val = pick4(MY_IP, int'(rx_index) - 38);
         default:       chk_en  = 1'b0;
      endcase
   end

   // Next-cycle view of the Rx tracker so a byte arriving with RxFrameEnd
   // is already counted, checked and captured when the accept is decided.
   always_comb begin
      idx_nxt   = rx_index;
      bcast_nxt = bcast_ok;
      ucast_nxt = ucast_ok;
      hdr_nxt   = hdr_ok;
      sha_nxt   = sha;
      spa_nxt   = spa;
      if (byte_in) begin
         if (rx_index != 7'd127) idx_nxt = rx_index + 7'd1;
         if (rx_index < 7'd6) begin
            bcast_nxt = bcast_ok & (RxByte == 8'hFF);
            ucast_nxt = ucast_ok & (RxByte == pick6(MY_PA, int'(rx_index)));
         end
         if (chk_en && (RxByte != chk_val)) hdr_nxt = 1'b0;
         if (rx_index >= 7'd22 && rx_index <= 7'd27)
            sha_nxt = (sha & ~(48'hFF << (8 * (27 - int'(rx_index)))))
                    | (48'(RxByte) << (8 * (27 - int'(rx_index))));
         if (rx_index >= 7'd28 && rx_index <= 7'd31)
            spa_nxt = (spa & ~(32'hFF << (8 * (31 - int'(rx_index)))))
                    | (32'(RxByte) << (8 * (31 - int'(rx_index))));
      end
   end

   assign accept = RxFrame & RxFrameEnd & RxCRC_OK & hdr_nxt
                 & (bcast_nxt | ucast_nxt) & (idx_nxt >= 7'd64);

   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_index <= 7'd0;
         bcast_ok <= 1'b1;
         ucast_ok <= 1'b1;
         hdr_ok   <= 1'b1;
         sha      <= 48'h0;
         spa      <= 32'h0;
      end else if (!RxFrame) begin
         rx_index <= 7'd0;
         bcast_ok <= 1'b1;
         ucast_ok <= 1'b1;
         hdr_ok   <= 1'b1;
      end else begin
         rx_index <= idx_nxt;
         bcast_ok <= bcast_nxt;
         ucast_ok <= ucast_nxt;
         hdr_ok   <= hdr_nxt;
         sha      <= sha_nxt;
         spa      <= spa_nxt;
      end
   end

   always_comb begin
      tx_byte = 8'h00;
      case (tx_index) inside
         [6'd0:6'd5]:   tx_byte = pick6(reply_sha, int'(tx_index));
         [6'd6:6'd11]:  tx_byte = pick6(MY_PA, int'(tx_index) - 6);
         6'd12:         tx_byte = 8'h08;
         6'd13:         tx_byte = 8'h06;
         6'd14:         tx_byte = 8'h00;
         6'd15:         tx_byte = 8'h01;
         6'd16:         tx_byte = 8'h08;
         6'd17:         tx_byte = 8'h00;
         6'd18:         tx_byte = 8'h06;
         6'd19:         tx_byte = 8'h04;
         6'd20:         tx_byte = 8'h00;
         6'd21:         tx_byte = 8'h02;
         [6'd22:6'd27]: tx_byte = pick6(MY_PA, int'(tx_index) - 22);
         [6'd28:6'd31]: tx_byte = pick4(MY_IP, int'(tx_index) - 28);
         [6'd32:6'd37]: tx_byte = pick6(reply_sha, int'(tx_index) - 32);
         [6'd38:6'd41]: tx_byte = pick4(reply_spa, int'(tx_index) - 38);
         default:       tx_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_nxt    = state;
      tx_index_nxt = tx_index;
      TxByte       = 8'h00;
      TxValid      = 1'b0;
      TxLast       = 1'b0;
      Busy         = 1'b0;
      load         = 1'b0;
      drop         = 1'b0;
      done         = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt    = SEND;
               tx_index_nxt = 6'd0;
               load         = 1'b1;
            end
         end
         SEND: begin
            TxByte  = tx_byte;
            TxValid = 1'b1;
            TxLast  = (tx_index == 6'd59);
            Busy    = 1'b1;
            drop    = accept;
            if (TxReady) begin
               if (tx_index == 6'd59) begin
                  state_nxt = IDLE;
                  done      = 1'b1;
               end else begin
                  tx_index_nxt = tx_index + 6'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         tx_index   <= 6'd0;
         reply_sha  <= 48'h0;
         reply_spa  <= 32'h0;
         ReplyCount <= 16'd0;
         DropCount  <= 16'd0;
      end else begin
         state    <= state_nxt;
         tx_index <= tx_index_nxt;
         if (load) begin
            reply_sha <= sha_nxt;
            reply_spa <= spa_nxt;
         end
         if (done) ReplyCount <= ReplyCount + 16'd1;
         if (drop) DropCount  <= DropCount + 16'd1;
      end
   end

endmodule

// File: tb/tb_arp_responder.sv
// Bench for arp_responder: directed ARP frames, a reply-queue model checked
// every cycle, and literal expectations for the reference request.
module tb_arp_responder;

   localparam logic [47:0] MY_MAC = 48'h16FD2204B161;
   localparam logic [31:0] MY_IP  = 32'hC0A80328;
   localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;
   localparam logic [47:0] SHA1   = 48'h0025649B6ADB;
   localparam logic [31:0] SPA1   = 32'hC0A8036D;
   localparam logic [31:0] SPA2   = 32'hC0A80307;

   logic        CLK = 1'b0;
   logic        RST, RxFrame, RxByteValid, RxFrameEnd, RxCRC_OK, TxReady;
   logic [7:0]  RxByte;
   logic [7:0]  TxByte;
   logic        TxValid, TxLast, Busy;
   logic [15:0] ReplyCount, DropCount;

   arp_responder dut (
      .CLK(CLK), .RST(RST), .RxFrame(RxFrame), .RxByte(RxByte),
      .RxByteValid(RxByteValid), .RxFrameEnd(RxFrameEnd), .RxCRC_OK(RxCRC_OK),
      .TxByte(TxByte), .TxValid(TxValid), .TxLast(TxLast), .TxReady(TxReady),
      .Busy(Busy), .ReplyCount(ReplyCount), .DropCount(DropCount)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   logic [7:0]  frm [0:63];
   logic [7:0]  cap [0:63];
   logic [7:0]  ref_cap [0:63];
   logic [7:0]  exp_q [$];
   bit          cur_ok = 1'b0;
   bit          mon_en = 1'b0;
   bit          model_busy = 1'b0;
   int          hs_cnt = 0;
   logic [15:0] m_replies = 16'd0;
   logic [15:0] m_drops = 16'd0;
   int          rdy_mode = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] b6(input logic [47:0] v, input int k);
      return 8'(v >> (8 * (5 - k)));
   endfunction

   function automatic logic [7:0] b4(input logic [31:0] v, input int k);
      return 8'(v >> (8 * (3 - k)));
   endfunction

   task automatic build(input logic [47:0] dst, input logic [47:0] s_ha, input logic [31:0] s_pa,
                        input logic [31:0] t_pa, input logic [15:0] op);
      logic [7:0] hdr [0:7];
      hdr = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04};
      for (int k = 0; k < 64; k++) frm[k] = 8'h00;
      for (int k = 0; k < 6; k++) begin
         frm[k]      = b6(dst, k);
         frm[6 + k]  = b6(s_ha, k);
         frm[22 + k] = b6(s_ha, k);
      end
      for (int k = 0; k < 8; k++) frm[12 + k] = hdr[k];
      frm[20] = op[15:8];
      frm[21] = op[7:0];
      for (int k = 0; k < 4; k++) begin
         frm[28 + k] = b4(s_pa, k);
         frm[38 + k] = b4(t_pa, k);
         frm[60 + k] = 8'hA5 + 8'(k);
      end
   endtask

   function automatic bit frame_ok(input int len, input bit crc);
      bit bc = 1'b1;
      bit uc = 1'b1;
      bit ok;
      logic [7:0] hdr [0:9];
      hdr = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};
      ok = crc && (len >= 64);
      for (int k = 0; k < 6; k++) begin
         bc = bc && (frm[k] == 8'hFF);
         uc = uc && (frm[k] == b6(MY_MAC, k));
      end
      ok = ok && (bc || uc);
      for (int k = 0; k < 10; k++) ok = ok && (frm[12 + k] == hdr[k]);
      for (int k = 0; k < 4; k++) ok = ok && (frm[38 + k] == b4(MY_IP, k));
      return ok;
   endfunction

   task automatic push_reply(input logic [47:0] s_ha, input logic [31:0] s_pa);
      logic [7:0] mid [0:9];
      mid = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02};
      for (int k = 0; k < 6; k++) exp_q.push_back(b6(s_ha, k));
      for (int k = 0; k < 6; k++) exp_q.push_back(b6(MY_MAC, k));
      for (int k = 0; k < 10; k++) exp_q.push_back(mid[k]);
      for (int k = 0; k < 6; k++) exp_q.push_back(b6(MY_MAC, k));
      for (int k = 0; k < 4; k++) exp_q.push_back(b4(MY_IP, k));
      for (int k = 0; k < 6; k++) exp_q.push_back(b6(s_ha, k));
      for (int k = 0; k < 4; k++) exp_q.push_back(b4(s_pa, k));
      for (int k = 0; k < 18; k++) exp_q.push_back(8'h00);
   endtask

   // Reply model: at most one reply in flight, later requests counted as drops.
   always @(negedge CLK) begin : monitor
      bit last;
      logic [47:0] s_ha;
      logic [31:0] s_pa;
      if (mon_en) begin
         last = 1'b0;
         chk("tx_valid", 64'(TxValid), 64'(model_busy));
         chk("busy", 64'(Busy), 64'(model_busy));
         chk("reply_count", 64'(ReplyCount), 64'(m_replies));
         chk("drop_count", 64'(DropCount), 64'(m_drops));
         if (model_busy && exp_q.size() > 0) begin
            chk("tx_byte", 64'(TxByte), 64'(exp_q[0]));
            chk("tx_last", 64'(TxLast), 64'(exp_q.size() == 1));
            if (TxReady) begin
               last = (exp_q.size() == 1);
               if (hs_cnt < 64) cap[hs_cnt] = TxByte;
               hs_cnt++;
               void'(exp_q.pop_front());
            end
         end else begin
            chk("tx_last_idle", 64'(TxLast), 64'd0);
         end
         if (RxFrame && RxFrameEnd && cur_ok) begin
            if (model_busy) begin
               m_drops = m_drops + 16'd1;
            end else begin
               for (int k = 0; k < 6; k++) s_ha = {s_ha[39:0], frm[22 + k]};
               for (int k = 0; k < 4; k++) s_pa = {s_pa[23:0], frm[28 + k]};
               push_reply(s_ha, s_pa);
               model_busy = 1'b1;
               hs_cnt = 0;
            end
         end
         if (last) begin
            model_busy = 1'b0;
            m_replies = m_replies + 16'd1;
         end
         if (RST) begin
            model_busy = 1'b0;
            exp_q.delete();
            m_replies = 16'd0;
            m_drops = 16'd0;
         end
      end
   end

   initial begin
      TxReady = 1'b1;
      forever begin
         @(posedge CLK);
         #1;
         case (rdy_mode)
            0: TxReady = 1'b1;
            1: TxReady = 1'b0;
            default: TxReady = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input int len, input bit crc, input bit with_end);
      cur_ok = frame_ok(len, crc);
      for (int i = 0; i < len; i++) begin
         RxFrame     = 1'b1;
         RxByte      = (i < 64) ? frm[i] : 8'h00;
         RxByteValid = 1'b1;
         RxFrameEnd  = with_end && (i == len - 1);
         RxCRC_OK    = crc;
         step();
      end
      RxFrame     = 1'b0;
      RxByteValid = 1'b0;
      RxFrameEnd  = 1'b0;
      RxCRC_OK    = 1'b0;
      step();
   endtask

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!model_busy) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) chk({name, "_timeout"}, 64'd1, 64'd0);
      repeat (2) step();
   endtask

   task automatic wait_hs(input int n, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (hs_cnt >= n) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) chk({name, "_timeout"}, 64'd1, 64'd0);
   endtask

   initial begin
      RST = 1'b1;
      RxFrame = 1'b0; RxByte = 8'h00; RxByteValid = 1'b0; RxFrameEnd = 1'b0; RxCRC_OK = 1'b0;
      repeat (3) step();
      chk("rst_txbyte", 64'(TxByte), 64'd0);
      chk("rst_txvalid", 64'(TxValid), 64'd0);
      chk("rst_txlast", 64'(TxLast), 64'd0);
      chk("rst_busy", 64'(Busy), 64'd0);
      chk("rst_replies", 64'(ReplyCount), 64'd0);
      chk("rst_drops", 64'(DropCount), 64'd0);
      RST = 1'b0;
      mon_en = 1'b1;
      step();

      // Rejected requests: wrong TPA, reply opcode, bad CRC, short frame, abandoned frame
      build(BCAST, SHA1, SPA1, 32'hC0A80329, 16'h0001); send(64, 1'b1, 1'b1);
      build(BCAST, SHA1, SPA1, MY_IP, 16'h0002);        send(64, 1'b1, 1'b1);
      build(BCAST, SHA1, SPA1, MY_IP, 16'h0001);        send(64, 1'b0, 1'b1);
      send(63, 1'b1, 1'b1);
      send(64, 1'b1, 1'b0);
      repeat (5) step();
      chk("neg_txvalid", 64'(TxValid), 64'd0);
      chk("neg_replies", 64'(ReplyCount), 64'd0);
      chk("neg_drops", 64'(DropCount), 64'd0);

      // Reference broadcast request
      send(64, 1'b1, 1'b1);
      wait_idle("ref");
      chk("ref_len", 64'(hs_cnt), 64'd60);
      chk("ref_b0", 64'(cap[0]), 64'h00);
      chk("ref_b1", 64'(cap[1]), 64'h25);
      chk("ref_b2", 64'(cap[2]), 64'h64);
      chk("ref_b3", 64'(cap[3]), 64'h9B);
      chk("ref_b4", 64'(cap[4]), 64'h6A);
      chk("ref_b5", 64'(cap[5]), 64'hDB);
      chk("ref_op_hi", 64'(cap[20]), 64'h00);
      chk("ref_op_lo", 64'(cap[21]), 64'h02);
      chk("ref_spa0", 64'(cap[38]), 64'hC0);
      chk("ref_spa1", 64'(cap[39]), 64'hA8);
      chk("ref_spa2", 64'(cap[40]), 64'h03);
      chk("ref_spa3", 64'(cap[41]), 64'h6D);
      chk("ref_pad59", 64'(cap[59]), 64'h00);
      chk("ref_replies", 64'(ReplyCount), 64'd1);
      for (int k = 0; k < 60; k++) ref_cap[k] = cap[k];

      // Same request under a stalling serializer
      rdy_mode = 2;
      send(64, 1'b1, 1'b1);
      wait_idle("stall");
      rdy_mode = 0;
      chk("stall_len", 64'(hs_cnt), 64'd60);
      for (int k = 0; k < 60; k++) chk("stall_seq", 64'(cap[k]), 64'(ref_cap[k]));

      // Second request arrives while the first reply is stalled
      RST = 1'b1; step(); RST = 1'b0; step();
      send(64, 1'b1, 1'b1);
      wait_hs(20, "drop_start");
      rdy_mode = 1;
      build(BCAST, SHA1, SPA2, MY_IP, 16'h0001);
      send(64, 1'b1, 1'b1);
      chk("drop_count1", 64'(DropCount), 64'd1);
      rdy_mode = 0;
      wait_idle("drop");
      chk("drop_len", 64'(hs_cnt), 64'd60);
      chk("drop_spa3", 64'(cap[41]), 64'h6D);
      chk("drop_replies", 64'(ReplyCount), 64'd1);

      // Unicast to our MAC is answered; mixed broadcast/unicast is not
      build(MY_MAC, SHA1, SPA1, MY_IP, 16'h0001);
      send(64, 1'b1, 1'b1);
      wait_idle("ucast");
      chk("ucast_replies", 64'(ReplyCount), 64'd2);
      build(48'hFFFFFF04B161, SHA1, SPA1, MY_IP, 16'h0001);
      send(64, 1'b1, 1'b1);
      repeat (5) step();
      chk("mixed_replies", 64'(ReplyCount), 64'd2);

      // Reset in the middle of a reply, then a fresh request
      build(BCAST, SHA1, SPA1, MY_IP, 16'h0001);
      send(64, 1'b1, 1'b1);
      wait_hs(30, "rst_mid");
      RST = 1'b1; step(); RST = 1'b0; step();
      chk("rst_mid_txvalid", 64'(TxValid), 64'd0);
      chk("rst_mid_replies", 64'(ReplyCount), 64'd0);
      send(64, 1'b1, 1'b1);
      wait_idle("post_rst");
      chk("post_rst_len", 64'(hs_cnt), 64'd60);
      chk("post_rst_replies", 64'(ReplyCount), 64'd1);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
